// File: rtl/aes_pkg.sv
// Shared constants and types for the AES ingress block loader.
package aes_pkg;

   localparam int AES_BYTES = 16;
   localparam int BYTE_W    = 8;

   localparam logic FT_DATA = 1'b0;
   localparam logic FT_KEY  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_KEY,
      LOAD_DATA,
      LAUNCH
   } ldr_state_t;

endpackage

// File: rtl/aes_byte_shifter.sv
// Byte shift register for the loader. It holds the first NBYTES-1 bytes and
// presents the full block formed with the incoming byte on the same cycle.
module aes_byte_shifter #(
   parameter int BYTE_W   = aes_pkg::BYTE_W,
   parameter int NBYTES   = aes_pkg::AES_BYTES,
   parameter bit LE_ORDER = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     shift_en,
   input  logic [BYTE_W-1:0]        din,
   output logic [NBYTES*BYTE_W-1:0] shifted
);

   localparam int W  = NBYTES * BYTE_W;
   localparam int SW = W - BYTE_W;

   logic [SW-1:0] held;
   logic [SW-1:0] held_n;

   // The final byte of a block is never stored, so the completing transfer can register the block directly.
   if (LE_ORDER) begin : g_le
      assign shifted = {din, held};
      assign held_n  = shifted[W-1:BYTE_W];
   end else begin : g_be
      assign shifted = {held, din};
      assign held_n  = shifted[SW-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         held <= '0;
      end else if (clr) begin
         held <= '0;
      end else if (shift_en) begin
         held <= held_n;
      end
   end

endmodule

// File: rtl/aes_block_loader.sv
// Byte-serial framer that assembles key and plaintext blocks for the AES pipeline.
// Define AES_LOADER_LE_EN to place the first accepted byte in bits [7:0].
module aes_block_loader #(
   parameter int DATA_LEN = 128,
   parameter int KEY_LEN  = 128,
   parameter int BYTE_W   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [BYTE_W-1:0]   s_data,
   input  logic                s_is_key,
   input  logic                s_last,
   output logic                blk_valid,
   output logic [DATA_LEN-1:0] blk_text,
   output logic                blk_key_valid,
   output logic [KEY_LEN-1:0]  blk_key,
   output logic                key_loaded,
   output logic                err_pulse
);

   import aes_pkg::*;

   localparam int         NBYTES   = DATA_LEN / BYTE_W;
   localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

`ifdef AES_LOADER_LE_EN
   localparam bit LE_ORDER = 1'b1;
`else
   localparam bit LE_ORDER = 1'b0;
`endif

   ldr_state_t          state, state_n;
   logic [3:0]          cnt, cnt_n;
   logic                ftype, ftype_n;
   logic                xfer;
   logic                last_byte;
   logic                shift_en;
   logic                clr;
   logic                err_n;
   logic                key_upd;
   logic                text_upd;
   logic [DATA_LEN-1:0] shifted;

   aes_byte_shifter #(
      .BYTE_W   (BYTE_W),
      .NBYTES   (NBYTES),
      .LE_ORDER (LE_ORDER)
   ) u_shifter (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .shift_en (shift_en),
      .din      (s_data),
      .shifted  (shifted)
   );

   // Ready is held low while in reset so nothing looks acceptable before the block is live.
   assign s_ready       = reset && (state != LAUNCH);
   assign blk_valid     = (state == LAUNCH);
   assign blk_key_valid = (state == LAUNCH);
   assign xfer          = s_valid && (state != LAUNCH);
   assign last_byte     = (cnt == LAST_IDX);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      ftype_n  = ftype;
      shift_en = 1'b0;
      clr      = 1'b0;
      err_n    = 1'b0;
      key_upd  = 1'b0;
      text_upd = 1'b0;

      case (state)
         IDLE: begin
            if (xfer) begin
               shift_en = 1'b1;
               ftype_n  = s_is_key;
               cnt_n    = 4'd1;
               state_n  = s_is_key ? LOAD_KEY : LOAD_DATA;
               if (s_last) begin
                  err_n   = 1'b1;
                  clr     = 1'b1;
                  cnt_n   = '0;
                  state_n = IDLE;
               end
            end
         end

         LOAD_KEY, LOAD_DATA: begin
            if (xfer) begin
               shift_en = 1'b1;
               cnt_n    = cnt + 4'd1;
               // A data block completing before any key exists is discarded like a framing error.
               if ((s_is_key != ftype) || (s_last != last_byte) ||
                   (last_byte && (ftype == FT_DATA) && !key_loaded)) begin
                  err_n   = 1'b1;
                  clr     = 1'b1;
                  cnt_n   = '0;
                  state_n = IDLE;
               end else if (last_byte) begin
                  cnt_n = '0;
                  if (ftype == FT_KEY) begin
                     key_upd = 1'b1;
                     state_n = IDLE;
                  end else begin
                     text_upd = 1'b1;
                     state_n  = LAUNCH;
                  end
               end
            end
         end

         LAUNCH: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         ftype      <= FT_DATA;
         blk_text   <= '0;
         blk_key    <= '0;
         key_loaded <= 1'b0;
         err_pulse  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         ftype     <= ftype_n;
         err_pulse <= err_n;
         if (key_upd) begin
            blk_key    <= shifted;
            key_loaded <= 1'b1;
         end
         if (text_upd) begin
            blk_text <= shifted;
         end
      end
   end

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: frame table plus a pulse scoreboard.
`timescale 1ns/1ps
module tb_aes_block_loader;

   localparam int K_NONE   = 0;
   localparam int K_ERR    = 1;
   localparam int K_LAUNCH = 2;

   localparam logic [127:0] KEY_PAT  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] DATA_PAT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] P2B      = {16{8'h2b}};
   localparam logic [127:0] PAA      = {16{8'haa}};
   localparam logic [127:0] P55      = {16{8'h55}};

   typedef struct {
      logic         is_key;
      logic [127:0] content;
      int           nbytes;
      int           last_at;
      int           toggle_at;
      bit           gaps;
      int           exp_kind;
      logic [127:0] exp_text;
      logic [127:0] exp_key;
      logic         exp_kl;
   } frame_vec_t;

   typedef struct {
      int           kind;
      int           due;
      logic [127:0] text;
      logic [127:0] key;
   } sb_rec_t;

   logic         clk      = 1'b0;
   logic         reset    = 1'b0;
   logic         s_valid  = 1'b0;
   logic [7:0]   s_data   = 8'h00;
   logic         s_is_key = 1'b0;
   logic         s_last   = 1'b0;
   logic         s_ready;
   logic         blk_valid;
   logic [127:0] blk_text;
   logic         blk_key_valid;
   logic [127:0] blk_key;
   logic         key_loaded;
   logic         err_pulse;

   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   sb_rec_t      sb[$];
   logic [127:0] held_text = '0;
   frame_vec_t   tbl[11];

   aes_block_loader #(
      .DATA_LEN (128),
      .KEY_LEN  (128),
      .BYTE_W   (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .s_is_key      (s_is_key),
      .s_last        (s_last),
      .blk_valid     (blk_valid),
      .blk_text      (blk_text),
      .blk_key_valid (blk_key_valid),
      .blk_key       (blk_key),
      .key_loaded    (key_loaded),
      .err_pulse     (err_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] ord(input logic [127:0] x);
`ifdef AES_LOADER_LE_EN
      for (int i = 0; i < 16; i++) ord[8*i +: 8] = x[127-8*i -: 8];
`else
      ord = x;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic idleCycle();
      @(negedge clk);
      s_valid  = 1'b0;
      s_data   = 8'($urandom);
      s_is_key = 1'($urandom);
      s_last   = 1'($urandom);
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic k, input logic l, output int xcyc);
      bit done;
      done = 1'b0;
      xcyc = 0;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         s_valid  = 1'b1;
         s_data   = d;
         s_is_key = k;
         s_last   = l;
         if (s_ready) begin
            @(posedge clk);
            xcyc = cyc;
            done = 1'b1;
            #1 s_valid = 1'b0;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         s_valid = 1'b0;
         $display("[TB] FAIL handshake_timeout: got no transfer expected one within 40 cycles");
      end
   endtask

   task automatic sendFrame(input frame_vec_t v);
      int xc;
      xc = 0;
      for (int i = 0; i < v.nbytes; i++) begin
         if (v.gaps) begin
            for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) idleCycle();
         end
         applyStimulus(v.content[127-8*i -: 8], (i == v.toggle_at) ? !v.is_key : v.is_key,
                       (i == v.last_at), xc);
      end
      if (v.exp_kind != K_NONE)
         sb.push_back('{kind: v.exp_kind, due: xc + 1, text: ord(v.exp_text), key: ord(v.exp_key)});
   endtask

   task automatic postCheck(input frame_vec_t v);
      repeat (2) @(negedge clk);
      if (v.exp_kind == K_LAUNCH) held_text = ord(v.exp_text);
      checkOutput("blk_key_hold", blk_key, ord(v.exp_key));
      checkOutput("key_loaded", {127'd0, key_loaded}, {127'd0, v.exp_kl});
      checkOutput("blk_text_hold", blk_text, held_text);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_blk_text"}, blk_text, '0);
      checkOutput({tag, "_blk_key"}, blk_key, '0);
      checkOutput({tag, "_key_loaded"}, {127'd0, key_loaded}, '0);
      checkOutput({tag, "_s_ready"}, {127'd0, s_ready}, '0);
      checkOutput({tag, "_blk_valid"}, {127'd0, blk_valid}, '0);
      checkOutput({tag, "_err_pulse"}, {127'd0, err_pulse}, '0);
   endtask

   // Every pulse must match the front of the scoreboard in kind, cycle and payload.
   always @(negedge clk) begin : monitor
      sb_rec_t e;
      bit      exp_launch;
      int      got_kind;
      if (sb.size() > 0 && sb[0].due < cyc) begin
         e = sb.pop_front();
         checks++;
         failures++;
         $display("[TB] FAIL pulse_missing: got no pulse expected kind %0d at cycle %0d", e.kind, e.due);
      end
      exp_launch = reset && sb.size() > 0 && sb[0].kind == K_LAUNCH && sb[0].due == cyc;
      checkOutput("s_ready", {127'd0, s_ready}, {127'd0, reset && !exp_launch});
      if (blk_valid || blk_key_valid || err_pulse) begin
         got_kind = blk_valid ? K_LAUNCH : K_ERR;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b expected none at cycle %0d",
                     blk_valid, err_pulse, cyc);
         end else begin
            e = sb.pop_front();
            checkOutput("pulse_kind", 128'(got_kind), 128'(e.kind));
            checkOutput("pulse_cycle", 128'(cyc), 128'(e.due));
            checkOutput("key_valid_pair", {127'd0, blk_key_valid}, {127'd0, e.kind == K_LAUNCH});
            checkOutput("err_exclusive", {127'd0, err_pulse}, {127'd0, e.kind == K_ERR});
            if (e.kind == K_LAUNCH) begin
               checkOutput("blk_text", blk_text, e.text);
               checkOutput("blk_key", blk_key, e.key);
            end
         end
      end
   end

   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog: got no finish expected end of test by 200 us");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tbl[0]  = '{is_key: 1'b0, content: DATA_PAT, nbytes: 16, last_at: 15, toggle_at: -1, gaps: 1'b0,
                  exp_kind: K_ERR, exp_text: '0, exp_key: '0, exp_kl: 1'b0};
      tbl[1]  = '{is_key: 1'b1, content: KEY_PAT, nbytes: 10, last_at: 9, toggle_at: -1, gaps: 1'b0,
                  exp_kind: K_ERR, exp_text: '0, exp_key: '0, exp_kl: 1'b0};
      tbl[2]  = '{is_key: 1'b1, content: P2B, nbytes: 16, last_at: 15, toggle_at: -1, gaps: 1'b0,
                  exp_kind: K_NONE, exp_text: '0, exp_key: P2B, exp_kl: 1'b1};
      tbl[3]  = '{is_key: 1'b0, content: PAA, nbytes: 5, last_at: -1, toggle_at: 4, gaps: 1'b0,
                  exp_kind: K_ERR, exp_text: '0, exp_key: P2B, exp_kl: 1'b1};
      tbl[4]  = '{is_key: 1'b0, content: PAA, nbytes: 16, last_at: 15, toggle_at: -1, gaps: 1'b0,
                  exp_kind: K_LAUNCH, exp_text: PAA, exp_key: P2B, exp_kl: 1'b1};
      tbl[5]  = '{is_key: 1'b0, content: P55, nbytes: 1, last_at: 0, toggle_at: -1, gaps: 1'b0,
                  exp_kind: K_ERR, exp_text: '0, exp_key: P2B, exp_kl: 1'b1};
      tbl[6]  = '{is_key: 1'b0, content: P55, nbytes: 16, last_at: -1, toggle_at: -1, gaps: 1'b0,
                  exp_kind: K_ERR, exp_text: '0, exp_key: P2B, exp_kl: 1'b1};
      tbl[7]  = '{is_key: 1'b1, content: KEY_PAT, nbytes: 16, last_at: 15, toggle_at: -1, gaps: 1'b0,
                  exp_kind: K_NONE, exp_text: '0, exp_key: KEY_PAT, exp_kl: 1'b1};
      tbl[8]  = '{is_key: 1'b0, content: DATA_PAT, nbytes: 16, last_at: 15, toggle_at: -1, gaps: 1'b0,
                  exp_kind: K_LAUNCH, exp_text: DATA_PAT, exp_key: KEY_PAT, exp_kl: 1'b1};
      tbl[9]  = '{is_key: 1'b1, content: KEY_PAT, nbytes: 16, last_at: 15, toggle_at: -1, gaps: 1'b1,
                  exp_kind: K_NONE, exp_text: '0, exp_key: KEY_PAT, exp_kl: 1'b1};
      tbl[10] = '{is_key: 1'b0, content: DATA_PAT, nbytes: 16, last_at: 15, toggle_at: -1, gaps: 1'b1,
                  exp_kind: K_LAUNCH, exp_text: DATA_PAT, exp_key: KEY_PAT, exp_kl: 1'b1};

      repeat (2) @(negedge clk);
      checkResetOutputs("reset");
      reset = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 11; n++) begin
         sendFrame(tbl[n]);
         postCheck(tbl[n]);
      end

      // Reset in the middle of a data frame, then a back-to-back key and data frame.
      sendFrame(tbl[2]);
      postCheck(tbl[2]);
      for (int i = 0; i < 8; i++) begin
         int xc;
         applyStimulus(8'haa, 1'b0, 1'b0, xc);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkResetOutputs("midframe_reset");
      @(negedge clk);
      reset     = 1'b1;
      held_text = '0;
      repeat (2) @(negedge clk);
      sendFrame(tbl[7]);
      sendFrame(tbl[8]);
      postCheck(tbl[8]);

      repeat (4) @(negedge clk);
      checkOutput("sb_empty", 128'(sb.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Byte-serial ingress framer directly upstream of the AES encryption pipeline top.
- Accepts a valid/ready byte stream of tagged frames and assembles 16-byte key and plaintext blocks.
- Drives the pipeline's plain_text/cipher_key inputs with simultaneous one-cycle data_valid_in/key_valid_in pulses, as the pipeline requires.
- The pipeline has no backpressure, so every launch is unconditional.

Parameters:
DATA_LEN, 128, plaintext block width in bits.
KEY_LEN, 128, cipher key width in bits; must equal DATA_LEN.
BYTE_W, 8, ingress byte width; block holds DATA_LEN/BYTE_W bytes (16).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
s_valid  in  1  ingress byte valid.
s_ready  out  1  ingress byte ready; a byte transfers when s_valid && s_ready.
s_data  in  BYTE_W  ingress byte.
s_is_key  in  1  1 = byte belongs to a key frame, 0 = plaintext frame.
s_last  in  1  marks the final (16th) byte of a frame.
blk_valid  out  1  one-cycle pulse; drives pipeline data_valid_in.
blk_text  out  DATA_LEN  assembled plaintext; drives plain_text.
blk_key_valid  out  1  one-cycle pulse, coincident with blk_valid; drives key_valid_in.
blk_key  out  KEY_LEN  current key; drives cipher_key.
key_loaded  out  1  a complete key frame has been received since reset.
err_pulse  out  1  one-cycle pulse on any discarded frame.

Behaviour:
- Reset values: all outputs 0, including s_ready, blk_text, blk_key and key_loaded. State is IDLE, byte counter is 0, shift register is cleared.
- s_ready = 1 in IDLE, LOAD_KEY and LOAD_DATA; 0 in LAUNCH.
- Byte order: first accepted byte goes to bits [DATA_LEN-1 -: 8], following FIPS-197 order. A 4-bit counter counts accepted bytes 0..15.
- IDLE: on the first transfer, latch s_is_key as the frame type, store the byte, set cnt=1 and go to LOAD_KEY or LOAD_DATA.
  - If s_last is set on this first byte, the frame is an error.
- LOAD_*: each transfer stores the byte and increments cnt. A frame error occurs if any of these hold:
  - s_is_key differs from the latched type;
  - s_last=1 while cnt<15;
  - s_last=0 while cnt==15.
- Frame error handling: discard partial contents, pulse err_pulse in the next cycle, return to IDLE. No launch and no key update occurs. The erroring byte is consumed.
- Key frame completion (16th byte with s_last): blk_key is updated and key_loaded is set in cycle N+1; next state is IDLE. There is no launch pulse.
  - A new key replaces the old one only at completion. Blocks launched earlier are unaffected.
- Data frame completion:
  - If key_loaded=0 at completion, it is a frame error.
  - Otherwise blk_text is updated in cycle N+1, state becomes LAUNCH, and blk_valid = blk_key_valid = 1 for exactly one cycle (N+1). Then IDLE.
- blk_text and blk_key hold their values between launches; only the valid signals pulse.
- Throughput: one block per 17 cycles under continuous s_valid. Latency is 1 cycle from last-byte accept to launch.
- Ingress rules:
  - Idle cycles (s_valid=0) inside a frame are legal; the counter holds.
  - s_data, s_is_key and s_last are ignored when no transfer occurs.
- Asynchronous reset mid-frame or during LAUNCH aborts immediately. No pulse is emitted and key_loaded clears.

Optional Feature:
- AES_LOADER_LE_EN defined: reversed byte order, with the first accepted byte placed in bits [7:0] for both key and data. All framing and timing are unchanged.
- Undefined: MSB-first order as above.

Decomposition:
- Shared package aes_pkg:
  - AES_BYTES=16 constant and the BYTE_W constant;
  - ldr_state_t enum {IDLE, LOAD_KEY, LOAD_DATA, LAUNCH};
  - frame-type constants FT_DATA=0, FT_KEY=1.
- One sub-module: aes_byte_shifter, a 16xBYTE_W shift register with clear, shift-enable and endianness selection.
- The top of this block holds the FSM, counter, key register and output registers.

Test Plan:
- Key frame 00,01,..,0f, then data frame 00,11,22,..,ff, back-to-back -> one blk_valid/blk_key_valid pulse 1 cycle after the 32nd transfer; blk_text=128'h00112233445566778899aabbccddeeff, blk_key=128'h000102030405060708090a0b0c0d0e0f.
- Data frame sent before any key frame -> err_pulse=1 one cycle after the 16th byte, no blk_valid, key_loaded=0.
- Key frame with s_last on byte 10 -> err_pulse, key_loaded stays 0; a following good key frame of all-0x2b bytes sets blk_key=128'h2b2b..2b.
- Data frame with s_is_key toggled at byte 5, then a correct data frame of all-0xaa bytes -> one err_pulse, then one launch with blk_text=128'haaaa..aa; s_ready=0 exactly in the launch cycle.
- Randomized s_valid gaps (~50% duty) on the key+data frames of scenario 1 -> same output values; exactly one launch pulse.
- Reset asserted at byte 8 of a data frame, then released -> all outputs 0, no pulse; the next full key+data sequence launches normally.
